// File: rtl/cfg_seq_pkg.sv
// cfg_seq_pkg: shared types and encoding helpers for the cfg_seq block.
//   state_t          sequencer state (IDLE / RUN / DONE)
//   sel_w()          width of wr_sel for a given number of field banks
//   sel_enable()     wr_sel code addressing the step-enable memory
//   sel_regs()       wr_sel code addressing the end/iteration registers
//   reg_en_end()     register-space address of the enable-memory end point
//   reg_iter()       register-space address of the iteration count
//   ptr_w()          pointer width for a memory of the given depth (min 1)
package cfg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int sel_w(input int num_fields);
    return $clog2(num_fields + 2);
  endfunction

  function automatic int sel_enable(input int num_fields);
    return num_fields;
  endfunction

  function automatic int sel_regs(input int num_fields);
    return num_fields + 1;
  endfunction

  function automatic int reg_en_end(input int num_fields);
    return num_fields;
  endfunction

  function automatic int reg_iter(input int num_fields);
    return num_fields + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cfg_seq_if.sv
// cfg_seq_if: write/load channel from the global configuration loader.
//   wr_valid   load request
//   wr_ready   load accepted when wr_valid & wr_ready
//   wr_sel     target: field bank, enable memory, or end/iteration registers
//   wr_addr    word address (register index for the register space)
//   wr_data    write data
//   wr_bit_en  per-bit write mask
// Modports: master = loader side, slave = cfg_seq side.
interface cfg_seq_if #(
  parameter int NUM_FIELDS = 4,
  parameter int FIELD_W    = 32,
  parameter int EN_DEPTH   = 32
);
  localparam int SEL_W  = cfg_seq_pkg::sel_w(NUM_FIELDS);
  localparam int ADDR_W = cfg_seq_pkg::ptr_w(EN_DEPTH);

  logic               wr_valid;
  logic               wr_ready;
  logic [SEL_W-1:0]   wr_sel;
  logic [ADDR_W-1:0]  wr_addr;
  logic [FIELD_W-1:0] wr_data;
  logic [FIELD_W-1:0] wr_bit_en;

  modport master (
    output wr_valid, wr_sel, wr_addr, wr_data, wr_bit_en,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_sel, wr_addr, wr_data, wr_bit_en,
    output wr_ready
  );
endinterface

// File: rtl/cfg_field_bank.sv
// cfg_field_bank: one configuration field bank (memory, read pointer, wrap
// point, registered output, optional parity).
//   clk, reset  clock, synchronous active-high reset
//   wr_en       merge wr_data under wr_bit_en into mem[wr_addr]
//   end_wr      load end_data into the wrap-point register
//   restart     pointer back to word 0 (sequence start)
//   step_en     read mem[ptr] into cfg_out and advance/wrap the pointer
//   cfg_out     registered field word
//   par_bad     parity mismatch on the word read this cycle
// Optional feature: CFG_PARITY_EN stores an even-parity bit per word.
module cfg_field_bank
  import cfg_seq_pkg::*;
#(
  parameter  int FIELD_W     = 32,
  parameter  int FIELD_DEPTH = 8,
  localparam int PTR_W       = ptr_w(FIELD_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_addr,
  input  logic [FIELD_W-1:0] wr_data,
  input  logic [FIELD_W-1:0] wr_bit_en,
  input  logic               end_wr,
  input  logic [PTR_W-1:0]   end_data,
  input  logic               restart,
  input  logic               step_en,
  output logic [FIELD_W-1:0] cfg_out,
  output logic               par_bad
);

  logic [FIELD_W-1:0] mem [FIELD_DEPTH];
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   end_q;
  logic [FIELD_W-1:0] merged;
  logic [FIELD_W-1:0] rd_word;

  assign merged  = (mem[wr_addr] & ~wr_bit_en) | (wr_data & wr_bit_en);
  assign rd_word = mem[ptr_q];

  // NOTE: the memory has no reset on purpose; a stored program survives
  // reset and it maps onto plain RAM without a clear path.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= merged;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      end_q   <= '0;
      cfg_out <= '0;
    end else begin
      if (end_wr) end_q <= end_data;
      if (restart) begin
        ptr_q <= '0;
      end else if (step_en) begin
        cfg_out <= rd_word;
        ptr_q   <= (ptr_q == end_q) ? '0 : ptr_q + 1'b1;
      end
    end
  end

`ifdef CFG_PARITY_EN
  logic par_mem [FIELD_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_addr] <= ^merged;
  end

  // Data is forwarded regardless; the mismatch only raises the sticky flag.
  assign par_bad = step_en && ((^rd_word) != par_mem[ptr_q]);
`else
  assign par_bad = 1'b0;
`endif

endmodule

// File: rtl/cfg_seq.sv
// cfg_seq: per-PE configuration sequencer. NUM_FIELDS field banks are stepped
// by a step-enable memory; iterations are counted and end with a done pulse.
//   clk, reset  clock, synchronous active-high reset
//   start       one-cycle pulse, IDLE -> RUN (ignored elsewhere)
//   stall       freeze sequencing while in RUN
//   wr          load channel (cfg_seq_if.slave), accepted only in IDLE
//   cfg_out     field i at [i*FIELD_W +: FIELD_W]
//   cfg_valid   cfg_out updated this cycle
//   busy        state == RUN
//   done        one-cycle pulse after the final step
//   par_err     sticky parity error, cleared by reset or accepted start
// Optional feature: CFG_PARITY_EN (parity in the field banks); without it
// par_err stays 0.
module cfg_seq
  import cfg_seq_pkg::*;
#(
  parameter int NUM_FIELDS  = 4,
  parameter int FIELD_W     = 32,
  parameter int FIELD_DEPTH = 8,
  parameter int EN_DEPTH    = 32,
  parameter int ITER_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stall,
  cfg_seq_if.slave                      wr,
  output logic [NUM_FIELDS*FIELD_W-1:0] cfg_out,
  output logic                          cfg_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          par_err
);

  localparam int SEL_W  = sel_w(NUM_FIELDS);
  localparam int ADDR_W = ptr_w(EN_DEPTH);
  localparam int PTR_W  = ptr_w(FIELD_DEPTH);

  localparam logic [SEL_W-1:0]  SEL_EN     = SEL_W'(sel_enable(NUM_FIELDS));
  localparam logic [SEL_W-1:0]  SEL_REGS   = SEL_W'(sel_regs(NUM_FIELDS));
  localparam logic [ADDR_W-1:0] REG_EN_END = ADDR_W'(reg_en_end(NUM_FIELDS));
  localparam logic [ADDR_W-1:0] REG_ITER   = ADDR_W'(reg_iter(NUM_FIELDS));

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     step_q, en_end_q;
  logic [ITER_W-1:0]     iter_q, iter_count_q, iter_inc;
  logic [NUM_FIELDS-1:0] en_mem [EN_DEPTH];
  logic [NUM_FIELDS-1:0] en_word, en_merged, bank_par_bad;
  logic                  ready, wr_fire, reg_fire, start_go;
  logic                  run_step, step_wrap, last_step;

  assign wr.wr_ready = ready;
  assign wr_fire     = wr.wr_valid && ready;
  assign reg_fire    = wr_fire && (wr.wr_sel == SEL_REGS);
  assign start_go    = start && (state_q == ST_IDLE);
  assign run_step    = (state_q == ST_RUN) && !stall;
  assign en_word     = en_mem[step_q];
  assign step_wrap   = (step_q == en_end_q);
  assign iter_inc    = iter_q + 1'b1;
  // A zero iteration count never matches, so the program runs until reset.
  assign last_step   = run_step && step_wrap && (iter_count_q != '0) &&
                       (iter_inc == iter_count_q);

  assign en_merged = (en_mem[wr.wr_addr] & ~wr.wr_bit_en[NUM_FIELDS-1:0]) |
                     (wr.wr_data[NUM_FIELDS-1:0] & wr.wr_bit_en[NUM_FIELDS-1:0]);

  always_ff @(posedge clk) begin
    if (wr_fire && (wr.wr_sel == SEL_EN)) en_mem[wr.wr_addr] <= en_merged;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)     state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output decode; done lines up with the final step's cfg_valid.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_RUN:  busy  = 1'b1;
      ST_DONE: done  = 1'b1;
      default: ;
    endcase
  end

  // Step / iteration counters, registers and status
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q       <= '0;
      en_end_q     <= '0;
      iter_q       <= '0;
      iter_count_q <= '0;
      cfg_valid    <= 1'b0;
      par_err      <= 1'b0;
    end else begin
      cfg_valid <= run_step;
      if (reg_fire && (wr.wr_addr == REG_EN_END)) en_end_q     <= wr.wr_data[ADDR_W-1:0];
      if (reg_fire && (wr.wr_addr == REG_ITER))   iter_count_q <= wr.wr_data[ITER_W-1:0];
      if (start_go) begin
        step_q  <= '0;
        iter_q  <= '0;
        par_err <= 1'b0;
      end else if (run_step) begin
        step_q <= step_wrap ? '0 : step_q + 1'b1;
        if (step_wrap)     iter_q  <= iter_inc;
        if (|bank_par_bad) par_err <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_bank
    cfg_field_bank #(
      .FIELD_W     (FIELD_W),
      .FIELD_DEPTH (FIELD_DEPTH)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_fire && (wr.wr_sel == SEL_W'(i))),
      .wr_addr   (wr.wr_addr[PTR_W-1:0]),
      .wr_data   (wr.wr_data),
      .wr_bit_en (wr.wr_bit_en),
      .end_wr    (reg_fire && (wr.wr_addr == ADDR_W'(i))),
      .end_data  (wr.wr_data[PTR_W-1:0]),
      .restart   (start_go),
      .step_en   (run_step && en_word[i]),
      .cfg_out   (cfg_out[i*FIELD_W +: FIELD_W]),
      .par_bad   (bank_par_bad[i])
    );
  end

endmodule

// File: tb/tb_cfg_seq.sv
// tb_cfg_seq: directed self-checking bench for cfg_seq (default parameters).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, i.e. away from the active edge.
module tb_cfg_seq;

  localparam int NF = 4;
  localparam int FW = 32;
  localparam int FD = 8;
  localparam int ED = 32;
  localparam int IW = 16;
  localparam int OW = NF * FW;

`ifdef CFG_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  localparam logic [31:0] W2 = 32'hFFFF_00FF;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stall;
  logic [OW-1:0] cfg_out;
  logic          cfg_valid;
  logic          busy;
  logic          done;
  logic          par_err;

  int n_tests;
  int n_fail;

  cfg_seq_if #(.NUM_FIELDS(NF), .FIELD_W(FW), .EN_DEPTH(ED)) wr_if ();

  cfg_seq #(
    .NUM_FIELDS  (NF),
    .FIELD_W     (FW),
    .FIELD_DEPTH (FD),
    .EN_DEPTH    (ED),
    .ITER_W      (IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .wr        (wr_if.slave),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .done      (done),
    .par_err   (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [4:0] addr,
                    input logic [31:0] data, input logic [31:0] mask);
    wr_if.wr_valid  = 1'b1;
    wr_if.wr_sel    = sel;
    wr_if.wr_addr   = addr;
    wr_if.wr_data   = data;
    wr_if.wr_bit_en = mask;
    tick();
    wr_if.wr_valid  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_step(input string tag, input logic [OW-1:0] exp_out, input logic exp_done);
    tick();
    check({tag, "_valid"}, cfg_valid, 1);
    check({tag, "_out"},   cfg_out,   exp_out);
    check({tag, "_done"},  done,      exp_done);
  endtask

  function automatic logic [OW-1:0] pack(input logic [31:0] f2, input logic [31:0] f1,
                                         input logic [31:0] f0);
    return {32'h0, f2, f1, f0};
  endfunction

  logic [31:0] t2_f0 [10];
  logic [31:0] t2_f1 [10];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    t2_f0 = '{32'hA0, 32'hA0, 32'hA1, 32'hA1, 32'hA2, 32'hA2, 32'hA3, 32'hA3, 32'hA0, 32'hA0};
    t2_f1 = '{32'h0,  32'hB0, 32'hB0, 32'hB1, 32'hB1, 32'hB2, 32'hB2, 32'hB0, 32'hB0, 32'hB1};

    reset = 1'b1; start = 1'b0; stall = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_sel = '0; wr_if.wr_addr = '0;
    wr_if.wr_data = '0; wr_if.wr_bit_en = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_cfg_out", cfg_out, 0);
    check("rst_valid", cfg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_par_err", par_err, 0);
    check("rst_wr_ready", wr_if.wr_ready, 1);

    // Single field, two iterations of two steps
    for (int k = 0; k < 4; k++) wr(3'd0, 5'(k), 32'hA0 + 32'(k), '1);
    wr(3'd5, 5'd0, 32'd3, '1);
    wr(3'd4, 5'd0, 32'h1, '1);
    wr(3'd4, 5'd1, 32'h1, '1);
    wr(3'd5, 5'd4, 32'd1, '1);
    wr(3'd5, 5'd5, 32'd2, '1);
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_latency_valid", cfg_valid, 0);
    for (int k = 0; k < 4; k++) expect_step("t1_step", pack(0, 0, 32'hA0 + 32'(k)), k == 3);
    tick();
    check("t1_after_done", done, 0);
    check("t1_after_busy", busy, 0);
    check("t1_after_valid", cfg_valid, 0);
    check("t1_after_ready", wr_if.wr_ready, 1);

    // Alternating enables, masked writes, independent wrap, stall
    for (int k = 0; k < 3; k++) wr(3'd1, 5'(k), 32'hB0 + 32'(k), '1);
    wr(3'd5, 5'd1, 32'd2, '1);
    wr(3'd2, 5'd0, 32'hFFFF_FFFF, '1);
    wr(3'd2, 5'd0, 32'h0, 32'h0000_FF00);
    wr(3'd4, 5'd0, 32'h4, 32'h4);
    wr(3'd4, 5'd1, 32'h2, '1);
    wr(3'd5, 5'd5, 32'd5, '1);
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      expect_step("t2_step", pack(W2, t2_f1[k], t2_f0[k]), k == 9);
      if (k == 3) begin
        stall = 1'b1;
        wr_if.wr_valid = 1'b1; wr_if.wr_sel = 3'd0; wr_if.wr_addr = 5'd1;
        wr_if.wr_data = 32'hDEAD_BEEF; wr_if.wr_bit_en = '1;
        for (int s = 0; s < 3; s++) begin
          tick();
          check("stall_valid", cfg_valid, 0);
          check("stall_out", cfg_out, pack(W2, t2_f1[3], t2_f0[3]));
          check("stall_busy", busy, 1);
          check("run_wr_ready", wr_if.wr_ready, 0);
        end
        stall = 1'b0;
        wr_if.wr_valid = 1'b0;
      end
    end
    tick();
    check("t2_after_busy", busy, 0);

    // Write and start in the same cycle, then reset mid-RUN
    wr_if.wr_valid = 1'b1; wr_if.wr_sel = 3'd0; wr_if.wr_addr = 5'd0;
    wr_if.wr_data = 32'hC0; wr_if.wr_bit_en = '1;
    pulse_start();
    wr_if.wr_valid = 1'b0;
    check("ws_busy", busy, 1);
    expect_step("ws_step", pack(W2, 32'hB1, 32'hC0), 0);
    expect_step("ws_step", pack(W2, 32'hB0, 32'hC0), 0);
    expect_step("ws_step", pack(W2, 32'hB0, 32'hA1), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_out", cfg_out, 0);
    check("midrst_valid", cfg_valid, 0);
    check("midrst_done", done, 0);

    // Restart without reloading: registers are back at 0, memories kept
    pulse_start();
    for (int k = 0; k < 3; k++) expect_step("free_step", pack(W2, 0, 32'hC0), 0);
    check("free_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wr(3'd5, 5'd0, 32'd3, '1);
    wr(3'd5, 5'd1, 32'd2, '1);
    wr(3'd5, 5'd4, 32'd1, '1);
    wr(3'd5, 5'd5, 32'd2, '1);
    pulse_start();
    expect_step("replay_step", pack(W2, 0, 32'hC0), 0);
    expect_step("replay_step", pack(W2, 32'hB0, 32'hC0), 0);
    expect_step("replay_step", pack(W2, 32'hB0, 32'hA1), 0);
    expect_step("replay_step", pack(W2, 32'hB1, 32'hA1), 1);
    tick();

    // Corrupt a stored word behind the parity bit
    dut.g_bank[0].u_bank.mem[0] = 32'h0000_00C1;
    pulse_start();
    expect_step("par_step", pack(W2, 32'hB1, 32'hC1), 0);
    check("par_set", par_err, PAR);
    expect_step("par_step", pack(W2, 32'hB0, 32'hC1), 0);
    expect_step("par_step", pack(W2, 32'hB0, 32'hA1), 0);
    expect_step("par_step", pack(W2, 32'hB1, 32'hA1), 1);
    check("par_sticky_done", par_err, PAR);
    tick();
    check("par_sticky_idle", par_err, PAR);
    pulse_start();
    check("par_start_clear", par_err, 0);
    tick();
    check("par_reset_again", par_err, PAR);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("par_rst_clear", par_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
